// File: rtl/e203_exu_dsp_wbck_pair_if.sv
// Bundle of MAC-result input, regfile writeback beat and status pulses for the
// DSP writeback pair sequencer. The master side produces MAC results and the slave side sequences them.
interface e203_exu_dsp_wbck_pair_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
);
    logic               mac_i_valid;
    logic               mac_i_ready;
    logic [RFIDX_W-1:0] mac_i_rdidx;
    logic               mac_i_rdw64;
    logic [XLEN-1:0]    mac_i_wdat;
    logic [XLEN-1:0]    mac_i_wdat_1;
    logic               mac_i_ov;
    logic               mac_i_err;
    logic               flush_req;
    logic               wbck_o_valid;
    logic               wbck_o_ready;
    logic [RFIDX_W-1:0] wbck_o_rdidx;
    logic [XLEN-1:0]    wbck_o_wdat;
    logic               ov_set;
    logic               err_o;
    logic               busy;

    modport master (
        output mac_i_valid, mac_i_rdidx, mac_i_rdw64, mac_i_wdat, mac_i_wdat_1,
               mac_i_ov, mac_i_err, flush_req, wbck_o_ready,
        input  mac_i_ready, wbck_o_valid, wbck_o_rdidx, wbck_o_wdat,
               ov_set, err_o, busy
    );

    modport slave (
        input  mac_i_valid, mac_i_rdidx, mac_i_rdw64, mac_i_wdat, mac_i_wdat_1,
               mac_i_ov, mac_i_err, flush_req, wbck_o_ready,
        output mac_i_ready, wbck_o_valid, wbck_o_rdidx, wbck_o_wdat,
               ov_set, err_o, busy
    );
endinterface

// File: rtl/e203_exu_dsp_wbck_pair.sv
// DSP MAC writeback sequencer: turns one 32-bit or 64-bit-pair MAC result into
// one or two regfile write beats (even reg = low word, odd reg = high word).
module e203_exu_dsp_wbck_pair #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
) (
    input logic clk,
    input logic rst,
    e203_exu_dsp_wbck_pair_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [RFIDX_W-1:0] r_rdidx;
    logic [XLEN-1:0]    r_wdat_1;
    logic               r_rdw64;
    logic               r_ov;

    logic               r_wbck_valid;
    logic [RFIDX_W-1:0] r_wbck_rdidx;
    logic [XLEN-1:0]    r_wbck_wdat;
    logic               r_busy;

    logic               w_beat_hs;
    logic               w_final_hs;
    logic               w_ready;
    logic               w_cap;
    logic               w_cap_err;
    logic [RFIDX_W-1:0] w_beat_rdidx;
    logic [XLEN-1:0]    w_beat_wdat;

    // Final beat = single-word LO beat or the HI beat of a pair.
    assign w_beat_hs  = r_wbck_valid & bus.wbck_o_ready;
    assign w_final_hs = w_beat_hs & (((r_state == S_LO) & ~r_rdw64) | (r_state == S_HI));
    assign w_ready    = ~bus.flush_req & ((r_state == S_IDLE) | w_final_hs);
    assign w_cap      = bus.mac_i_valid & w_ready;
    assign w_cap_err  = bus.mac_i_err | (bus.mac_i_rdw64 & bus.mac_i_rdidx[0]);

    // Next state and next beat contents; a completing op may be replaced by a new capture.
    always_comb begin
        w_next       = r_state;
        w_beat_rdidx = r_wbck_rdidx;
        w_beat_wdat  = r_wbck_wdat;

        if (w_cap) begin
            w_next = w_cap_err ? S_ERR : S_LO;
        end else if (w_final_hs || (r_state == S_ERR)) begin
            w_next = S_IDLE;
        end else if (bus.flush_req) begin
            w_next = S_IDLE;
        end else if ((r_state == S_LO) && w_beat_hs) begin
            w_next = S_HI;
        end

        if (w_cap) begin
            w_beat_rdidx = bus.mac_i_rdw64 ? {bus.mac_i_rdidx[RFIDX_W-1:1], 1'b0}
                                           : bus.mac_i_rdidx;
            w_beat_wdat  = bus.mac_i_wdat;
        end else if ((r_state == S_LO) && (w_next == S_HI)) begin
            w_beat_rdidx = {r_rdidx[RFIDX_W-1:1], 1'b1};
            w_beat_wdat  = r_wdat_1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wbck_valid <= 1'b0;
            r_wbck_rdidx <= '0;
            r_wbck_wdat  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_wbck_valid <= (w_next == S_LO) || (w_next == S_HI);
            r_wbck_rdidx <= w_beat_rdidx;
            r_wbck_wdat  <= w_beat_wdat;
            r_busy       <= (w_next != S_IDLE);
        end
    end

    // Holding registers for the rest of the op (high word, pair flag, OV).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdidx  <= '0;
            r_wdat_1 <= '0;
            r_rdw64  <= 1'b0;
            r_ov     <= 1'b0;
        end else if (w_cap) begin
            r_rdidx  <= bus.mac_i_rdidx;
            r_wdat_1 <= bus.mac_i_wdat_1;
            r_rdw64  <= bus.mac_i_rdw64;
            r_ov     <= bus.mac_i_ov;
        end
    end

    assign bus.mac_i_ready  = w_ready;
    assign bus.wbck_o_valid = r_wbck_valid;
    assign bus.wbck_o_rdidx = r_wbck_rdidx;
    assign bus.wbck_o_wdat  = r_wbck_wdat;
    assign bus.busy         = r_busy;
    // Commit pulses fire in the completing cycle; a flush in ERR suppresses err_o.
    assign bus.ov_set       = w_final_hs & r_ov;
    assign bus.err_o        = (r_state == S_ERR) & ~bus.flush_req;

endmodule

// File: tb/tb_e203_exu_dsp_wbck_pair.sv
// Directed bench for the DSP writeback pair sequencer.
module tb_e203_exu_dsp_wbck_pair;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    e203_exu_dsp_wbck_pair_if #(.XLEN(32), .RFIDX_W(5)) bus ();

    e203_exu_dsp_wbck_pair #(.XLEN(32), .RFIDX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic w64,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic ov, input logic err);
        bus.mac_i_valid  = v;
        bus.mac_i_rdidx  = rd;
        bus.mac_i_rdw64  = w64;
        bus.mac_i_wdat   = d0;
        bus.mac_i_wdat_1 = d1;
        bus.mac_i_ov     = ov;
        bus.mac_i_err    = err;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle_in();
        bus.flush_req    = 1'b0;
        bus.wbck_o_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_valid", 64'(bus.wbck_o_valid), 64'd0);
        chk("rst_rdidx", 64'(bus.wbck_o_rdidx), 64'd0);
        chk("rst_wdat",  64'(bus.wbck_o_wdat),  64'd0);
        chk("rst_ov",    64'(bus.ov_set),       64'd0);
        chk("rst_err",   64'(bus.err_o),        64'd0);
        chk("rst_busy",  64'(bus.busy),         64'd0);
        chk("rst_ready", 64'(bus.mac_i_ready),  64'd1);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.mac_i_ready), 64'd1);

        // Single write, ov=1, ready held high
        step();
        drive(1'b1, 5'd5, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        #1;
        chk("s_cap_ready", 64'(bus.mac_i_ready), 64'd1);
        step();
        idle_in();
        #1;
        chk("s_valid", 64'(bus.wbck_o_valid), 64'd1);
        chk("s_rdidx", 64'(bus.wbck_o_rdidx), 64'd5);
        chk("s_wdat",  64'(bus.wbck_o_wdat),  64'h1234_5678);
        chk("s_ov",    64'(bus.ov_set),       64'd1);
        chk("s_ready", 64'(bus.mac_i_ready),  64'd1);
        chk("s_busy",  64'(bus.busy),         64'd1);
        step();
        chk("s_done_valid", 64'(bus.wbck_o_valid), 64'd0);
        chk("s_done_ov",    64'(bus.ov_set),       64'd0);
        chk("s_done_busy",  64'(bus.busy),         64'd0);

        // Pair with 3 cycles of backpressure
        bus.wbck_o_ready = 1'b0;
        drive(1'b1, 5'd6, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 1'b0);
        #1;
        chk("p_cap_ready", 64'(bus.mac_i_ready), 64'd1);
        step();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            bus.wbck_o_ready = (i == 3);
            #1;
            chk("p_lo_valid", 64'(bus.wbck_o_valid), 64'd1);
            chk("p_lo_rdidx", 64'(bus.wbck_o_rdidx), 64'd6);
            chk("p_lo_wdat",  64'(bus.wbck_o_wdat),  64'hAAAA_0001);
            chk("p_lo_ov",    64'(bus.ov_set),       64'd0);
            chk("p_lo_ready", 64'(bus.mac_i_ready),  64'd0);
            step();
        end
        #1;
        chk("p_hi_valid", 64'(bus.wbck_o_valid), 64'd1);
        chk("p_hi_rdidx", 64'(bus.wbck_o_rdidx), 64'd7);
        chk("p_hi_wdat",  64'(bus.wbck_o_wdat),  64'hBBBB_0002);
        chk("p_hi_ov",    64'(bus.ov_set),       64'd1);
        chk("p_hi_ready", 64'(bus.mac_i_ready),  64'd1);
        step();
        chk("p_done_valid", 64'(bus.wbck_o_valid), 64'd0);
        chk("p_done_busy",  64'(bus.busy),         64'd0);

        // Illegal pair (odd destination)
        drive(1'b1, 5'd7, 1'b1, 32'h5555_5555, 32'h6666_6666, 1'b1, 1'b0);
        step();
        idle_in();
        #1;
        chk("e_valid", 64'(bus.wbck_o_valid), 64'd0);
        chk("e_err",   64'(bus.err_o),        64'd1);
        chk("e_ov",    64'(bus.ov_set),       64'd0);
        chk("e_busy",  64'(bus.busy),         64'd1);
        chk("e_ready", 64'(bus.mac_i_ready),  64'd0);
        step();
        chk("e_done_err",  64'(bus.err_o), 64'd0);
        chk("e_done_busy", 64'(bus.busy),  64'd0);

        // Flush in HI after the LO beat was accepted
        drive(1'b1, 5'd10, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        step();
        idle_in();
        #1;
        chk("f_lo_rdidx", 64'(bus.wbck_o_rdidx), 64'd10);
        chk("f_lo_wdat",  64'(bus.wbck_o_wdat),  64'h1111_1111);
        chk("f_lo_ov",    64'(bus.ov_set),       64'd0);
        step();
        bus.wbck_o_ready = 1'b0;
        bus.flush_req    = 1'b1;
        drive(1'b1, 5'd2, 1'b0, 32'h9, 32'h0, 1'b0, 1'b0);
        #1;
        chk("f_hi_rdidx", 64'(bus.wbck_o_rdidx), 64'd11);
        chk("f_hi_ov",    64'(bus.ov_set),       64'd0);
        chk("f_hi_ready", 64'(bus.mac_i_ready),  64'd0);
        step();
        bus.flush_req    = 1'b0;
        bus.wbck_o_ready = 1'b1;
        idle_in();
        #1;
        chk("f_after_valid", 64'(bus.wbck_o_valid), 64'd0);
        chk("f_after_busy",  64'(bus.busy),         64'd0);
        chk("f_after_ov",    64'(bus.ov_set),       64'd0);

        // Flush coincident with the final handshake still commits
        drive(1'b1, 5'd3, 1'b0, 32'h0000_0033, 32'h0, 1'b1, 1'b0);
        step();
        idle_in();
        bus.flush_req = 1'b1;
        #1;
        chk("fc_valid", 64'(bus.wbck_o_valid), 64'd1);
        chk("fc_ov",    64'(bus.ov_set),       64'd1);
        chk("fc_ready", 64'(bus.mac_i_ready),  64'd0);
        step();
        bus.flush_req = 1'b0;
        #1;
        chk("fc_after_busy", 64'(bus.busy), 64'd0);

        // Three singles back-to-back, one of them to x0
        drive(1'b1, 5'd1, 1'b0, 32'hA1, 32'h0, 1'b0, 1'b0);
        #1;
        chk("b_ready0", 64'(bus.mac_i_ready), 64'd1);
        step();
        drive(1'b1, 5'd0, 1'b0, 32'hA2, 32'h0, 1'b0, 1'b0);
        #1;
        chk("b_beat1", {31'd0, bus.wbck_o_valid, 27'd0, bus.wbck_o_rdidx, bus.wbck_o_wdat[31:0]} , {31'd0, 1'b1, 27'd0, 5'd1, 32'hA1});
        chk("b_ready1", 64'(bus.mac_i_ready), 64'd1);
        step();
        drive(1'b1, 5'd3, 1'b0, 32'hA3, 32'h0, 1'b0, 1'b0);
        #1;
        chk("b_beat2", {31'd0, bus.wbck_o_valid, 27'd0, bus.wbck_o_rdidx, bus.wbck_o_wdat[31:0]}, {31'd0, 1'b1, 27'd0, 5'd0, 32'hA2});
        chk("b_ready2", 64'(bus.mac_i_ready), 64'd1);
        step();
        idle_in();
        #1;
        chk("b_beat3", {31'd0, bus.wbck_o_valid, 27'd0, bus.wbck_o_rdidx, bus.wbck_o_wdat[31:0]}, {31'd0, 1'b1, 27'd0, 5'd3, 32'hA3});
        chk("b_ov3", 64'(bus.ov_set), 64'd0);
        step();
        chk("b_done_valid", 64'(bus.wbck_o_valid), 64'd0);

        // Asynchronous reset in the middle of a pair
        bus.wbck_o_ready = 1'b0;
        drive(1'b1, 5'd12, 1'b1, 32'hC0C0_0001, 32'hC0C0_0002, 1'b1, 1'b0);
        step();
        idle_in();
        #1;
        chk("r_pre_valid", 64'(bus.wbck_o_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_valid_drop", 64'(bus.wbck_o_valid), 64'd0);
        chk("r_busy_drop",  64'(bus.busy),         64'd0);
        step();
        rst = 1'b0;
        bus.wbck_o_ready = 1'b1;
        step();
        chk("r_after_busy",  64'(bus.busy),         64'd0);
        chk("r_after_ready", 64'(bus.mac_i_ready),  64'd1);
        chk("r_after_valid", 64'(bus.wbck_o_valid), 64'd0);
        chk("r_after_ov",    64'(bus.ov_set),       64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
